adxl355_read_sched: RTL

//  Schedules the shared ADXL355 SPI byte master between automatic sample fetch and ESP32 pass-through.
//  On each 1-clk drdy pulse it runs one burst read of XDATA3..ZDATA1 and streams the bytes to the sample buffer.
//  CPU requests are granted only while idle. A drdy arriving during a CPU access is pended; a second one counts as overrun.

---
 rtl/adxl355_sched_pkg.sv | 20 ++
 rtl/adxl355_cs_gap.sv | 36 +++
 rtl/adxl355_read_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/adxl355_sched_pkg.sv
// Shared types and helpers for the ADXL355 read scheduler.
`timescale 1ns/1ps
package adxl355_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DATA = 3'd2,
        GAP  = 3'd3,
        CPU  = 3'd4
    } state_t;

    localparam logic RD_BIT = 1'b1;

    // ADXL355 SPI command byte: register address in [7:1], read flag in [0].
    function automatic logic [7:0] rd_cmd(input logic [7:0] addr);
        return {addr[6:0], RD_BIT};
    endfunction

endpackage

// File: rtl/adxl355_cs_gap.sv
// Loadable down-counter timing the chip-select high gap between SPI transactions.
`timescale 1ns/1ps
module adxl355_cs_gap #(
    parameter int CS_GAP_CLKS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic done_o
);

    localparam int CW = $clog2(CS_GAP_CLKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Loading CS_GAP_CLKS-1 makes done_o rise on the last of CS_GAP_CLKS gap cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(CS_GAP_CLKS - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/adxl355_read_sched.sv
// Arbitrates the ADXL355 SPI byte master between drdy-triggered burst reads and ESP32 pass-through.
// Optional ADXL355_TIMESTAMP_EN appends a 16-bit drdy count as two extra buffer bytes per burst.
`timescale 1ns/1ps
module adxl355_read_sched
    import adxl355_sched_pkg::*;
#(
    parameter int         SAMPLE_BYTES = 9,
    parameter logic [7:0] START_REG    = 8'h08,
    parameter int         CS_GAP_CLKS  = 4,
    parameter int         OVR_BITS     = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_drdy,
    input  logic                i_cpu_req,
    output logic                o_cpu_gnt,
    output logic                o_spi_csn,
    output logic                o_spi_start,
    output logic [7:0]          o_spi_tx,
    input  logic                i_spi_done,
    input  logic [7:0]          i_spi_rx,
    output logic                o_wr_en,
    output logic [3:0]          o_wr_addr,
    output logic [7:0]          o_wr_data,
    output logic                o_busy,
    output logic [OVR_BITS-1:0] o_overrun_cnt,
    output logic [2:0]          o_dbg_state
);

    localparam logic [3:0] LAST_IDX = 4'(SAMPLE_BYTES - 1);

    state_t              state_q, state_d;
    logic                csn_q, csn_d;
    logic                start_q, start_d;
    logic [7:0]          tx_q, tx_d;
    logic                gnt_q, gnt_d;
    logic                wr_en_q, wr_en_d;
    logic [3:0]          wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [3:0]          idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [OVR_BITS-1:0] ovr_q, ovr_d;
    logic                gap_cpu_q, gap_cpu_d;
    logic                gap_load;
    logic                gap_done;

`ifdef ADXL355_TIMESTAMP_EN
    localparam logic [3:0] TS_HI_IDX = 4'(SAMPLE_BYTES);
    localparam logic [3:0] TS_LO_IDX = 4'(SAMPLE_BYTES + 1);
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] ts_lat_q, ts_lat_d;
`endif

    adxl355_cs_gap #(.CS_GAP_CLKS(CS_GAP_CLKS)) u_cs_gap (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .load_i (gap_load),
        .done_o (gap_done)
    );

    // SPI byte handshake: o_spi_start is a 1-clk request carrying o_spi_tx; the master
    // answers with a 1-clk i_spi_done and i_spi_rx; a new start is issued only after done.
    always_comb begin
        state_d   = state_q;
        csn_d     = csn_q;
        start_d   = 1'b0;
        tx_d      = tx_q;
        gnt_d     = gnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        gap_cpu_d = gap_cpu_q;
        gap_load  = 1'b0;
`ifdef ADXL355_TIMESTAMP_EN
        ts_cnt_d  = ts_cnt_q + 16'(i_drdy);
        ts_lat_d  = ts_lat_q;
`endif

        if (i_drdy && (pend_q || state_q == CMD || state_q == DATA) && ovr_q != '1) begin
            ovr_d = ovr_q + 1'b1;
        end
        if (i_drdy && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_q || i_drdy) begin
                    state_d = CMD;
                    csn_d   = 1'b0;
                    start_d = 1'b1;
                    tx_d    = rd_cmd(START_REG);
                    pend_d  = 1'b0;
`ifdef ADXL355_TIMESTAMP_EN
                    ts_lat_d = ts_cnt_d;
`endif
                end else if (i_cpu_req) begin
                    state_d = CPU;
                    gnt_d   = 1'b1;
                end
            end
            CMD: begin
                if (i_spi_done) begin
                    state_d = DATA;
                    start_d = 1'b1;
                    tx_d    = 8'h00;
                    idx_d   = 4'd0;
                end
            end
            DATA: begin
`ifdef ADXL355_TIMESTAMP_EN
                // Indices past the last data byte are timestamp writes, one per clock.
                if (idx_q > LAST_IDX) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = (idx_q == TS_HI_IDX) ? ts_lat_q[15:8] : ts_lat_q[7:0];
                    if (idx_q == TS_LO_IDX) begin
                        state_d   = GAP;
                        gap_load  = 1'b1;
                        gap_cpu_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else
`endif
                if (i_spi_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = i_spi_rx;
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 4'd1;
                        start_d = 1'b1;
                        tx_d    = 8'h00;
                    end else begin
                        csn_d = 1'b1;
`ifdef ADXL355_TIMESTAMP_EN
                        idx_d = idx_q + 4'd1;
`else
                        state_d   = GAP;
                        gap_load  = 1'b1;
                        gap_cpu_d = 1'b0;
`endif
                    end
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end
            end
            CPU: begin
                if (!i_cpu_req) begin
                    state_d   = GAP;
                    gnt_d     = 1'b0;
                    gap_load  = 1'b1;
                    gap_cpu_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            csn_q     <= 1'b1;
            start_q   <= 1'b0;
            tx_q      <= 8'h00;
            gnt_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 8'h00;
            idx_q     <= 4'd0;
            pend_q    <= 1'b0;
            ovr_q     <= '0;
            gap_cpu_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            csn_q     <= csn_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            gap_cpu_q <= gap_cpu_d;
        end
    end

`ifdef ADXL355_TIMESTAMP_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_cnt_q <= 16'h0000;
            ts_lat_q <= 16'h0000;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_lat_q <= ts_lat_d;
        end
    end
`endif

    assign o_cpu_gnt     = gnt_q;
    assign o_spi_csn     = csn_q;
    assign o_spi_start   = start_q;
    assign o_spi_tx      = tx_q;
    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_overrun_cnt = ovr_q;
    assign o_busy        = (state_q == CMD) || (state_q == DATA) || (state_q == GAP && !gap_cpu_q);
    assign o_dbg_state   = state_q;

endmodule
